// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int CNT_W = 4;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between load/store port and memory.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous byte-enabled write port, one async read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [31:0]      wdata,
    input  logic [LANES-1:0] be,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with valid/ready request and response.
// Define DMEM_BYTE_LANE_EN to honour req_be on writes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [LANES-1:0] lane_en;
    logic [31:0]      mem_rdata;
    logic             addr_err;
    logic             access;
    logic             mem_we;

`ifdef DMEM_BYTE_LANE_EN
    logic [LANES-1:0] be_q, be_d;
    assign lane_en = be_q;
`else
    logic unused_be;
    assign lane_en   = '1;
    assign unused_be = ^bus.req_be;
`endif

    assign addr_err = (addr_q[1:0] != 2'b00) ||
                      (addr_q[31:2] >= DEPTH_W);
    assign access   = (state_q == ST_WAIT) && (cnt_q == '0);
    assign mem_we   = access && we_q && !addr_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .be    (lane_en),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DMEM_BYTE_LANE_EN
        be_d    = be_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
`ifdef DMEM_BYTE_LANE_EN
                    be_d    = bus.req_be;
`endif
                    cnt_d   = CNT_W'(WAIT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Writes and faulting accesses return zero data.
                    rdata_d = (we_q || addr_err) ? '0 : mem_rdata;
                    err_d   = addr_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_BYTE_LANE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_BYTE_LANE_EN
            be_q    <= be_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the ARM processor's load/store port. It accepts one word-wide read or write request through a valid/ready handshake and inserts a parameterised number of wait states. It then returns read data or a write acknowledgement through a second valid/ready handshake. It sits on the memory side of the datapath's DataAdr/WriteData/ReadData interface and replaces the zero-latency ideal data memory in multicycle and pipelined builds.

## Interface
- DEPTH, 64, number of 32-bit words stored; legal word indices are 0..DEPTH-1
- WAIT, 2, wait states inserted between request acceptance and the memory access (0..15)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clock clk
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte-lane write enables; used only when DMEM_BYTE_LANE_EN is defined
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator consumes the response
- rsp_rdata  out  32  load data; 0 for writes and errors
- rsp_err  out  1  access was misaligned or out of range

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid & req_ready, capture we, addr, wdata and be; load cnt = WAIT; go to WAIT.
- **WAIT**
  - req_ready = 0.
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0: perform the access, register rsp_rdata and rsp_err, and go to RESP.
- **RESP**
  - rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready at a clock edge.
  - On that edge, go to IDLE and clear rsp_rdata and rsp_err to 0.
- **Error condition:** addr[1:0] != 0, or addr[31:2] >= DEPTH.
  - The memory is not modified.
  - rsp_rdata = 0 and rsp_err = 1.
- **Read:** rsp_rdata = mem[addr[31:2]] and rsp_err = 0.
- **Write:** mem[addr[31:2]] <= wdata, rsp_rdata = 0 and rsp_err = 0. The write happens on the access edge only.
- A request presented while the responder is not in IDLE is ignored, because req_ready = 0.
- The cnt width is 4 bits.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- **Reset values:** state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, cnt = 0.
- **Latency:** rsp_valid rises WAIT+1 cycles after the accepting edge. With WAIT = 0, it is high on the cycle after acceptance.
- **Back-to-back:** after the response handshake edge, req_ready is high in the following cycle. There is no same-cycle turnaround, so the minimum spacing between transactions is WAIT+3 cycles when rsp_ready is held high.
- **Backpressure:** rsp_valid may stay high for any number of cycles. Outputs must not change while waiting for rsp_ready.
- **Reset during WAIT:** if reset asserts before the access edge, the pending write is dropped and memory is unchanged. The FSM returns to IDLE immediately, asynchronously.
- **Reset during RESP:** the pending response is discarded and rsp_valid drops immediately.
- **Read-after-write:** a read to the same address in the next transaction returns the new data.

## Configuration
- **DMEM_BYTE_LANE_EN defined:**
  - A write updates only the byte lanes whose req_be bit is 1.
  - req_be = 4'b0000 is a legal no-op write: the response is returned with rsp_err = 0.
  - Reads ignore req_be and return the full word.
  - The alignment rule is unchanged: addr[1:0] must be 0.
- **DMEM_BYTE_LANE_EN undefined:**
  - The req_be port still exists but is ignored.
  - Every write updates all four bytes, as if req_be = 4'b1111.

## Structure
- **Package dmem_pkg contains:**
  - the state enum (IDLE, WAIT, RESP);
  - the counter width constant CNT_W = 4;
  - the byte-lane count constant LANES = 4.
- **Sub-module dmem_array contains:**
  - the storage array and its single synchronous write port (with byte enables);
  - one combinational read port.
- dmem_responder holds the FSM, the request capture registers, the wait counter and the error check.

## Test plan
- **Read after write, WAIT = 2:** write 0xDEADBEEF to 0x10, then read 0x10 → rsp_valid rises 3 cycles after each acceptance; rsp_rdata = 0xDEADBEEF; rsp_err = 0.
- **Misaligned write:** write 0x12345678 to 0x13 → rsp_err = 1; a subsequent read of 0x10 still returns its previous value.
- **Out-of-range access, DEPTH = 64:** read 0x100 → rsp_err = 1 and rsp_rdata = 0.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay stable; req_valid asserted during this time is not accepted.
- **Reset mid-operation:** assert reset one cycle after accepting a write of 0xAAAAAAAA to 0x20 → req_ready = 1 and rsp_valid = 0 immediately; a later read of 0x20 returns the old value.
- **Byte-lane write, DMEM_BYTE_LANE_EN defined:** word 0x20 holds 0x11223344; write 0xFFFFFFFF with req_be = 4'b0101 → a read of 0x20 returns 0x11FF33FF.
